layer_stream_ctrl: RTL

- Sequences one inference pass through a layer of parallel neurons.
- Accepts an input feature vector on a valid/ready stream and broadcasts it, one word per beat, to every neuron of the layer.
- Captures each neuron's activation on that neuron's outvalid, then drains the results in neuron-index order on an output stream.
- Sits between the AXI input FIFO and the layer's neuron array. Weight and bias loading are not handled here.

---
 rtl/layer_stream_ctrl_pkg.sv | 22 ++
 rtl/layer_stream_ctrl_if.sv | 41 ++++
 rtl/layer_stream_ctrl_result_buf.sv | 47 ++++
 rtl/layer_stream_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/layer_stream_ctrl_pkg.sv
// Shared types and helpers for the layer stream controller.
// Holds the FSM state encoding and a width helper used to size counters and indices.
package layer_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Never returns less than 1, so a one-neuron layer still gets a usable index bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/layer_stream_ctrl_if.sv
// Bundles the upstream stream, the neuron-array broadcast and capture signals,
// the result stream and the status flags. The slave modport is the controller side.
interface layer_stream_ctrl_if
    import layer_stream_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_W      = 16,
    parameter int OUT_W       = 16
);
    localparam int IDX_W = clog2(NUM_NEURONS);

    logic                         start;
    logic                         in_valid;
    logic [DATA_W-1:0]            in_data;
    logic                         in_ready;
    logic                         nrn_in_valid;
    logic [DATA_W-1:0]            nrn_in_data;
    logic [NUM_NEURONS-1:0]       nrn_outvalid;
    logic [NUM_NEURONS*OUT_W-1:0] nrn_out;
    logic                         res_valid;
    logic [OUT_W-1:0]             res_data;
    logic [IDX_W-1:0]             res_idx;
    logic                         res_last;
    logic                         res_ready;
    logic                         busy;
    logic                         done;
    logic                         err_timeout;

    modport master (
        output start, in_valid, in_data, nrn_outvalid, nrn_out, res_ready,
        input  in_ready, nrn_in_valid, nrn_in_data, res_valid, res_data,
               res_idx, res_last, busy, done, err_timeout
    );

    modport slave (
        input  start, in_valid, in_data, nrn_outvalid, nrn_out, res_ready,
        output in_ready, nrn_in_valid, nrn_in_data, res_valid, res_data,
               res_idx, res_last, busy, done, err_timeout
    );

endinterface

// File: rtl/layer_stream_ctrl_result_buf.sv
// Per-neuron result register file: first outvalid wins, later repeats are ignored.
// clr_i wipes values and the captured mask so a missing neuron drains as zero next pass.
module layer_stream_ctrl_result_buf
    import layer_stream_ctrl_pkg::*;
#(
    parameter  int NUM_NEURONS = 30,
    parameter  int OUT_W       = 16,
    localparam int IDX_W       = clog2(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic [NUM_NEURONS-1:0]       cap_en_i,
    input  logic [NUM_NEURONS*OUT_W-1:0] data_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [OUT_W-1:0]             rd_data_o,
    output logic                         all_captured_o
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [OUT_W-1:0]       entry_val [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] captured;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_entry
            logic [OUT_W-1:0] val_q;
            logic             cap_q;

            always_ff @(posedge clk) begin
                if (rst || clr_i) begin
                    val_q <= '0;
                    cap_q <= 1'b0;
                end else if (cap_en_i[gi] && !cap_q) begin
                    val_q <= data_i[gi*OUT_W +: OUT_W];
                    cap_q <= 1'b1;
                end
            end

            assign entry_val[gi] = val_q;
            assign captured[gi]  = cap_q;
        end
    endgenerate

    assign all_captured_o = &captured;
    assign rd_data_o      = (rd_idx_i <= LAST_IDX) ? entry_val[rd_idx_i] : '0;

endmodule

// File: rtl/layer_stream_ctrl.sv
// Runs one inference pass: broadcast NUM_WEIGHTS input words to the neuron array,
// collect every neuron's activation (or give up after TIMEOUT), then drain in index order.
module layer_stream_ctrl
    import layer_stream_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int NUM_WEIGHTS = 128,
    parameter int DATA_W      = 16,
    parameter int OUT_W       = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic                clk,
    input  logic                rst,
    layer_stream_ctrl_if.slave  bus
);
    localparam int IDX_W  = clog2(NUM_NEURONS);
    localparam int BEAT_W = clog2(NUM_WEIGHTS);
    localparam int TMO_W  = clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_WEIGHTS - 1);
    localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(TIMEOUT - 1);

    state_e              state_q;
    logic                in_ready_q;
    logic                nrn_in_valid_q;
    logic [DATA_W-1:0]   nrn_in_data_q;
    logic                res_valid_q;
    logic [IDX_W-1:0]    res_idx_q;
    logic                done_q;
    logic                err_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_q;

    logic                   beat;
    logic                   res_hs;
    logic                   last_hs;
    logic                   all_captured;
    logic [NUM_NEURONS-1:0] cap_en;

    assign beat    = bus.in_valid && in_ready_q;
    assign res_hs  = res_valid_q && bus.res_ready;
    assign last_hs = res_hs && (res_idx_q == LAST_IDX);
    assign cap_en  = (state_q == STREAM || state_q == WAIT) ? bus.nrn_outvalid : '0;

    layer_stream_ctrl_result_buf #(
        .NUM_NEURONS (NUM_NEURONS),
        .OUT_W       (OUT_W)
    ) u_result_buf (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (last_hs),
        .cap_en_i       (cap_en),
        .data_i         (bus.nrn_out),
        .rd_idx_i       (res_idx_q),
        .rd_data_o      (bus.res_data),
        .all_captured_o (all_captured)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            nrn_in_valid_q <= 1'b0;
            nrn_in_data_q  <= '0;
            res_valid_q    <= 1'b0;
            res_idx_q      <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            beat_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            nrn_in_valid_q <= beat;
            done_q         <= 1'b0;
            if (beat) nrn_in_data_q <= bus.in_data;

            case (state_q)
                IDLE: begin
                    // done_q marks the cycle right after a pass; a start there is dropped.
                    if (bus.start && !done_q) begin
                        state_q    <= STREAM;
                        in_ready_q <= 1'b1;
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            in_ready_q <= 1'b0;
                            tmo_cnt_q  <= '0;
                            state_q    <= WAIT;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (all_captured || tmo_cnt_q == LAST_TMO) begin
                        err_q       <= !all_captured;
                        res_valid_q <= 1'b1;
                        res_idx_q   <= '0;
                        state_q     <= DRAIN;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_hs) begin
                        if (res_idx_q == LAST_IDX) begin
                            res_valid_q <= 1'b0;
                            res_idx_q   <= '0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            res_idx_q <= res_idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.nrn_in_valid = nrn_in_valid_q;
    assign bus.nrn_in_data  = nrn_in_data_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_idx      = res_idx_q;
    assign bus.res_last     = res_valid_q && (res_idx_q == LAST_IDX);
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.err_timeout  = err_q;

endmodule
